// File: rtl/tune_pkg.sv
// Shared types and widths for the tone output stage: envelope states,
// volume/PWM widths and the floored volume decrement.
package tune_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    SUSTAIN = 2'd2
  } env_state_t;

  localparam int VOL_W = 4;
  localparam int PWM_W = 4;

  // One decay step that can never go below the sustain floor.
  function automatic logic [VOL_W-1:0] vol_dec(input logic [VOL_W-1:0] vol,
                                               input logic [VOL_W-1:0] floor_vol);
    logic [VOL_W-1:0] res;
    if (vol > floor_vol) begin
      res = vol - VOL_W'(1);
    end else begin
      res = floor_vol;
    end
    return res;
  endfunction

endpackage

// File: rtl/tune_pwm_mod.sv
// PWM modulator: free-running 4-bit ramp compared against the envelope volume,
// gated by the tone level and the stage enable.
module tune_pwm_mod
  import tune_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tone,
  input  logic [3:0] volume,
  output logic       pwm_out
);

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pwm_q, pwm_d;

  // Ramp keeps running in every state so the duty phase never stalls.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    pwm_d     = en & tone & (pwm_cnt_q < volume);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= {PWM_W{1'b0}};
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/tune_envelope_pwm.sv
// Speaker output stage: detects note onsets after a silent gap, applies a
// decaying volume envelope and drives the pin through the PWM modulator.
module tune_envelope_pwm
  import tune_pkg::*;
#(
  parameter int SILENCE_CYCLES = 64,
  parameter int DECAY_DIV      = 4096,
  parameter int VOL_MAX        = 15,
  parameter int VOL_MIN        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tone_in,
  output logic       pwm_out,
  output logic       note_start,
  output logic [3:0] volume
);

  localparam int SIL_W = $clog2(SILENCE_CYCLES + 1);
  localparam int DEC_W = $clog2(DECAY_DIV);
  localparam logic [SIL_W-1:0] SIL_MAX  = SIL_W'(SILENCE_CYCLES);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_DIV - 1);
  localparam logic [VOL_W-1:0] V_MAX    = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] V_MIN    = VOL_W'(VOL_MIN);

  logic             tone_q, tone_qq;
  logic [SIL_W-1:0] sil_cnt_q, sil_cnt_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  env_state_t       state_q, state_d;
  logic [VOL_W-1:0] volume_q, volume_d, vol_step_s;
  logic             note_start_q, note_start_d;
  logic             edge_s, gap_s;

  assign edge_s     = tone_q ^ tone_qq;
  assign gap_s      = (sil_cnt_q == SIL_MAX);
  assign vol_step_s = vol_dec(volume_q, V_MIN);

  // An edge clears the count even on the cycle it would have reached the threshold.
  always_comb begin
    sil_cnt_d = sil_cnt_q;
    if (edge_s) begin
      sil_cnt_d = {SIL_W{1'b0}};
    end else if (!gap_s) begin
      sil_cnt_d = sil_cnt_q + SIL_W'(1);
    end else begin
      sil_cnt_d = sil_cnt_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    volume_d     = volume_q;
    dec_cnt_d    = dec_cnt_q;
    note_start_d = 1'b0;
    if (!en) begin
      state_d   = IDLE;
      volume_d  = {VOL_W{1'b0}};
      dec_cnt_d = {DEC_W{1'b0}};
    end else if (edge_s && gap_s) begin
      state_d      = PLAY;
      volume_d     = V_MAX;
      dec_cnt_d    = {DEC_W{1'b0}};
      note_start_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          volume_d = {VOL_W{1'b0}};
        end
        PLAY: begin
          if (gap_s) begin
            state_d  = IDLE;
            volume_d = {VOL_W{1'b0}};
          end else if (dec_cnt_q == DEC_LAST) begin
            dec_cnt_d = {DEC_W{1'b0}};
            volume_d  = vol_step_s;
            if (vol_step_s == V_MIN) begin
              state_d = SUSTAIN;
            end else begin
              state_d = PLAY;
            end
          end else begin
            dec_cnt_d = dec_cnt_q + DEC_W'(1);
          end
        end
        SUSTAIN: begin
          if (gap_s) begin
            state_d  = IDLE;
            volume_d = {VOL_W{1'b0}};
          end else begin
            volume_d = V_MIN;
          end
        end
        default: begin
          state_d  = IDLE;
          volume_d = {VOL_W{1'b0}};
        end
      endcase
    end
  end

  // Counter preloads to the threshold so the first edge after reset is an onset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_q       <= 1'b0;
      tone_qq      <= 1'b0;
      sil_cnt_q    <= SIL_MAX;
      dec_cnt_q    <= {DEC_W{1'b0}};
      state_q      <= IDLE;
      volume_q     <= {VOL_W{1'b0}};
      note_start_q <= 1'b0;
    end else begin
      tone_q       <= tone_in;
      tone_qq      <= tone_q;
      sil_cnt_q    <= sil_cnt_d;
      dec_cnt_q    <= dec_cnt_d;
      state_q      <= state_d;
      volume_q     <= volume_d;
      note_start_q <= note_start_d;
    end
  end

  tune_pwm_mod u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .tone    (tone_q),
    .volume  (volume_q),
    .pwm_out (pwm_out)
  );

  assign note_start = note_start_q;
  assign volume     = volume_q;

endmodule

// File: tb/tb_tune_envelope_pwm.sv
// Bench for tune_envelope_pwm: an event-level model (quiet time, note age,
// volume as a function of age) predicts every output cycle by cycle.
module tb_tune_envelope_pwm;

  localparam int SIL  = 64;
  localparam int DIV  = 16;
  localparam int VMAX = 15;
  localparam int VMIN = 2;

  logic       clk, rst_n, en, tone_in;
  logic       pwm_out, note_start;
  logic [3:0] volume;

  int checks = 0;
  int fails  = 0;

  logic       m_tq, m_tqq, m_play;
  int         m_quiet, m_age, m_pc;
  logic       exp_pwm, exp_ns, pre_tq;
  logic [3:0] exp_vol, pre_vol;

  tune_envelope_pwm #(
    .SILENCE_CYCLES (SIL),
    .DECAY_DIV      (DIV),
    .VOL_MAX        (VMAX),
    .VOL_MIN        (VMIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tone_in    (tone_in),
    .pwm_out    (pwm_out),
    .note_start (note_start),
    .volume     (volume)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Volume of a note that started age cycles ago, floored at the sustain level.
  function automatic logic [3:0] env_level(input logic play, input int age);
    int lvl;
    if (!play) return 4'd0;
    lvl = VMAX - age / DIV;
    if (lvl < VMIN) lvl = VMIN;
    return 4'(lvl);
  endfunction

  task automatic model_reset();
    m_tq = 1'b0; m_tqq = 1'b0; m_play = 1'b0;
    m_quiet = SIL; m_age = 0; m_pc = 0;
    exp_pwm = 1'b0; exp_ns = 1'b0; exp_vol = 4'd0;
    pre_tq = 1'b0; pre_vol = 4'd0;
  endtask

  task automatic tick();
    logic e, g;
    @(posedge clk);
    pre_vol = exp_vol;
    pre_tq  = m_tq;
    e = m_tq ^ m_tqq;
    g = (m_quiet == SIL);
    exp_pwm = en & m_tq & (m_pc < int'(exp_vol));
    m_pc = (m_pc + 1) % 16;
    m_tqq = m_tq;
    m_tq  = tone_in;
    m_quiet = e ? 0 : ((m_quiet < SIL) ? m_quiet + 1 : SIL);
    exp_ns = 1'b0;
    if (!en) m_play = 1'b0;
    else if (e && g) begin m_play = 1'b1; m_age = 0; exp_ns = 1'b1; end
    else if (g) m_play = 1'b0;
    else if (m_play) m_age++;
    exp_vol = env_level(m_play, m_age);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; tone_in = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({pwm_out, note_start, volume} !== 6'd0) begin
      fails++;
      $display("FAIL reset_hold: got pwm=%b ns=%b vol=%0d want all 0", pwm_out, note_start, volume);
    end
    #19 rst_n = 1'b1;
    tick();
    tone_in = 1'b1;
    tick();
    tick();
    checks++;
    if (note_start !== 1'b1 || volume !== 4'd15) begin
      fails++;
      $display("FAIL reset_first_onset: got ns=%b vol=%0d want ns=1 vol=15", note_start, volume);
    end
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0) tone_in = ~tone_in;
      tick();
      checks++;
      if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
        fails++;
        $display("FAIL reset_play: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
      end
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({pwm_out, note_start, volume} !== 6'd0) begin
      fails++;
      $display("FAIL reset_mid_note: got pwm=%b ns=%b vol=%0d want all 0", pwm_out, note_start, volume);
    end
    model_reset();
    tone_in = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    tone_in = 1'b1;
    tick();
    tick();
    checks++;
    if (note_start !== 1'b1 || volume !== 4'd15) begin
      fails++;
      $display("FAIL reset_retrigger: got ns=%b vol=%0d want ns=1 vol=15", note_start, volume);
    end
  endtask

  task automatic test_onset();
    int pulses = 0;
    int since = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      checks++;
      if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
        fails++;
        $display("FAIL onset_idle: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
      end
    end
    for (int i = 0; i < 200; i++) begin
      if (i % 10 == 0) tone_in = ~tone_in;
      tick();
      if (note_start) pulses++;
      if (exp_ns) since = 0;
      else if (since >= 0) since++;
      checks++;
      if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
        fails++;
        $display("FAIL onset_model: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
      end
      if (since >= 0 && since < DIV) begin
        checks++;
        if (volume !== 4'd15) begin
          fails++;
          $display("FAIL onset_full_volume: got %0d want 15 at cycle %0d", volume, since);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL onset_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_decay();
    int k = -1;
    int hold = 0;
    for (int i = 0; i < 80; i++) tick();
    for (int i = 0; i < 260; i++) begin
      if (hold == 0) begin tone_in = ~tone_in; hold = $urandom_range(1, 12); end
      hold--;
      tick();
      if (exp_ns) k = 0;
      else if (k >= 0) k++;
      checks++;
      if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
        fails++;
        $display("FAIL decay_model: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
      end
      if (k == 13 * DIV - 1) begin
        checks++;
        if (volume !== 4'd3) begin
          fails++;
          $display("FAIL decay_before_floor: got %0d want 3", volume);
        end
      end
      if (k == 13 * DIV) begin
        checks++;
        if (volume !== 4'd2) begin
          fails++;
          $display("FAIL decay_floor: got %0d want 2", volume);
        end
      end
    end
    checks++;
    if (volume !== 4'd2) begin
      fails++;
      $display("FAIL decay_sustain: got %0d want 2", volume);
    end
  endtask

  task automatic test_gap();
    int n = 0;
    tone_in = ~tone_in;
    while (n < 100) begin
      tick();
      n++;
      checks++;
      if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
        fails++;
        $display("FAIL gap_model: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
      end
      if (volume == 4'd0) break;
    end
    checks++;
    if (n !== SIL + 3) begin
      fails++;
      $display("FAIL gap_timing: volume reached 0 after %0d clocks want %0d", n, SIL + 3);
    end
    tone_in = ~tone_in;
    tick();
    tick();
    checks++;
    if (note_start !== 1'b1 || volume !== 4'd15) begin
      fails++;
      $display("FAIL gap_new_note: got ns=%b vol=%0d want ns=1 vol=15", note_start, volume);
    end
  endtask

  task automatic test_boundary();
    int gaps [9] = '{10, 64, 63, 64, 10, 65, 66, 70, 20};
    for (int j = 0; j < 9; j++) begin
      tone_in = ~tone_in;
      for (int t = 0; t < gaps[j]; t++) begin
        tick();
        checks++;
        if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
          fails++;
          $display("FAIL boundary_model: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
        end
        if (j >= 1 && j <= 4) begin
          checks++;
          if (note_start !== 1'b0 || volume === 4'd0) begin
            fails++;
            $display("FAIL boundary_no_gap: got ns=%b vol=%0d want ns=0 vol>0", note_start, volume);
          end
        end
      end
    end
  endtask

  task automatic test_pwm();
    int win = 0;
    int highs = 0;
    tone_in = 1'b0;
    for (int i = 0; i < 80; i++) tick();
    for (int i = 0; i < 160; i++) begin
      if (i % 10 == 0) tone_in = ~tone_in;
      tick();
      checks++;
      if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
        fails++;
        $display("FAIL pwm_model: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
      end
    end
    tone_in = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      checks++;
      if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
        fails++;
        $display("FAIL pwm_model: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
      end
      if (pre_vol == 4'd4 && pre_tq) begin
        win++;
        highs += int'(pwm_out);
      end
    end
    checks++;
    if (win !== 16 || highs !== 4) begin
      fails++;
      $display("FAIL pwm_duty4: got %0d high of %0d want 4 of 16", highs, win);
    end
    tone_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!pre_tq) begin
        checks++;
        if (pwm_out !== 1'b0) begin
          fails++;
          $display("FAIL pwm_tone_low: got %b want 0", pwm_out);
        end
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if ({pwm_out, note_start, volume} !== 6'd0) begin
      fails++;
      $display("FAIL pwm_disable: got pwm=%b ns=%b vol=%0d want all 0", pwm_out, note_start, volume);
    end
    en = 1'b1;
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin tone_in = ~tone_in; hold = $urandom_range(1, 70); end
      hold--;
      en = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 999) < 3) begin
        rst_n = 1'b0;
        #2;
        checks++;
        if ({pwm_out, note_start, volume} !== 6'd0) begin
          fails++;
          $display("FAIL random_reset: got pwm=%b ns=%b vol=%0d want all 0", pwm_out, note_start, volume);
        end
        model_reset();
        rst_n = 1'b1;
      end
      tick();
      checks++;
      if ({pwm_out, note_start, volume} !== {exp_pwm, exp_ns, exp_vol}) begin
        fails++;
        $display("FAIL random_model: got %b/%b/%0d want %b/%b/%0d", pwm_out, note_start, volume, exp_pwm, exp_ns, exp_vol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_onset();
    test_decay();
    test_gap();
    test_boundary();
    test_pwm();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
